// File: rtl/second_game_player_ctrl.sv
// Player square controller: per-frame movement, collision capture and IDLE/PLAY/DEAD game state.
// Optional macro SECOND_GAME_WRAP_X_EN: x wraps at the playfield edges instead of clamping.
module second_game_player_ctrl #(
    parameter int SECOND_GAME_SCREEN_WIDTH  = 400,
    parameter int SECOND_GAME_SCREEN_HEIGHT = 600,
    parameter int SECOND_GAME_PLAYER_SIZE   = 20,
    parameter int SECOND_GAME_INIT_X        = 200,
    parameter int SECOND_GAME_INIT_Y        = 500,
    parameter int SECOND_GAME_STEP          = 4,
    parameter int XW = $clog2(SECOND_GAME_SCREEN_WIDTH),
    parameter int YW = $clog2(SECOND_GAME_SCREEN_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_tick,
    input  logic          i_start,
    input  logic          i_btn_left,
    input  logic          i_btn_right,
    input  logic          i_btn_up,
    input  logic          i_btn_down,
    input  logic          i_disp_enbl,
    input  logic [10:0]   i_h_coord,
    input  logic [9:0]    i_v_coord,
    input  logic          i_is_obstacle,
    output logic [XW-1:0] o_screen_square_x,
    output logic [YW-1:0] o_screen_square_y,
    output logic [1:0]    o_game_state,
    output logic          o_game_over,
    output logic [15:0]   o_score
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic signed [11:0] C_SIZE  = 12'(SECOND_GAME_PLAYER_SIZE);
    localparam logic signed [11:0] C_STEP  = 12'(SECOND_GAME_STEP);
    localparam logic signed [11:0] C_X_MAX = 12'(SECOND_GAME_SCREEN_WIDTH - 1 - SECOND_GAME_PLAYER_SIZE);
    localparam logic signed [11:0] C_Y_MAX = 12'(SECOND_GAME_SCREEN_HEIGHT - 1 - SECOND_GAME_PLAYER_SIZE);
    localparam logic [11:0]        C_USIZE = 12'(SECOND_GAME_PLAYER_SIZE);
    localparam logic [XW-1:0]      C_INIT_X = XW'(SECOND_GAME_INIT_X);
    localparam logic [YW-1:0]      C_INIT_Y = YW'(SECOND_GAME_INIT_Y);

    state_t         r_state, w_state_nx;
    logic [XW-1:0]  r_x, w_x_nx;
    logic [YW-1:0]  r_y, w_y_nx;
    logic [15:0]    r_score, w_score_nx;
    logic           r_hit_pending, w_hit_nx;
    logic           r_start_prev;
    logic           r_game_over;

    logic               w_start_edge;
    logic               w_hit_now;
    logic               w_hit_any;
    logic [11:0]        w_x_ext, w_y_ext, w_h_ext, w_v_ext;
    logic signed [11:0] w_dx, w_dy, w_x_sum, w_y_sum, w_x_lim, w_y_lim;

    assign w_start_edge = i_start & ~r_start_prev;

    assign w_x_ext = 12'(r_x);
    assign w_y_ext = 12'(r_y);
    assign w_h_ext = 12'(i_h_coord);
    assign w_v_ext = 12'(i_v_coord);

    // Clamping keeps the centre at least SIZE from zero, so the lower box bound cannot underflow.
    assign w_hit_now = (r_state == S_PLAY) && i_disp_enbl && i_is_obstacle
                    && (w_h_ext >= w_x_ext - C_USIZE) && (w_h_ext <= w_x_ext + C_USIZE)
                    && (w_v_ext >= w_y_ext - C_USIZE) && (w_v_ext <= w_y_ext + C_USIZE);
    assign w_hit_any = r_hit_pending | w_hit_now;

    always_comb begin
        w_dx = '0;
        if (i_btn_right && !i_btn_left)      w_dx = C_STEP;
        else if (i_btn_left && !i_btn_right) w_dx = -C_STEP;
        w_dy = '0;
        if (i_btn_down && !i_btn_up)         w_dy = C_STEP;
        else if (i_btn_up && !i_btn_down)    w_dy = -C_STEP;

        w_x_sum = $signed(w_x_ext) + w_dx;
        w_y_sum = $signed(w_y_ext) + w_dy;

`ifdef SECOND_GAME_WRAP_X_EN
        if (w_x_sum < C_SIZE)       w_x_lim = C_X_MAX;
        else if (w_x_sum > C_X_MAX) w_x_lim = C_SIZE;
        else                        w_x_lim = w_x_sum;
`else
        if (w_x_sum < C_SIZE)       w_x_lim = C_SIZE;
        else if (w_x_sum > C_X_MAX) w_x_lim = C_X_MAX;
        else                        w_x_lim = w_x_sum;
`endif
        if (w_y_sum < C_SIZE)       w_y_lim = C_SIZE;
        else if (w_y_sum > C_Y_MAX) w_y_lim = C_Y_MAX;
        else                        w_y_lim = w_y_sum;
    end

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_score_nx = r_score;
        // The tick consumes the accumulated hit (including this cycle's) and then clears it.
        w_hit_nx   = i_frame_tick ? 1'b0 : w_hit_any;

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nx = S_PLAY;
                    w_score_nx = '0;
                    w_hit_nx   = 1'b0;
                end
            end
            S_PLAY: begin
                if (i_frame_tick) begin
                    if (w_hit_any) begin
                        w_state_nx = S_DEAD;
                    end else begin
                        w_x_nx = XW'(w_x_lim);
                        w_y_nx = YW'(w_y_lim);
                        if (r_score != '1) w_score_nx = r_score + 16'd1;
                    end
                end
            end
            S_DEAD: begin
                if (w_start_edge) begin
                    w_state_nx = S_IDLE;
                    w_x_nx     = C_INIT_X;
                    w_y_nx     = C_INIT_Y;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_x           <= C_INIT_X;
            r_y           <= C_INIT_Y;
            r_score       <= '0;
            r_hit_pending <= 1'b0;
            r_start_prev  <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_x           <= w_x_nx;
            r_y           <= w_y_nx;
            r_score       <= w_score_nx;
            r_hit_pending <= w_hit_nx;
            r_start_prev  <= i_start;
            r_game_over   <= (w_state_nx == S_DEAD);
        end
    end

    assign o_screen_square_x = r_x;
    assign o_screen_square_y = r_y;
    assign o_game_state      = r_state;
    assign o_game_over       = r_game_over;
    assign o_score           = r_score;

endmodule

// File: tb/tb_second_game_player_ctrl.sv
// Directed bench for second_game_player_ctrl; expected values are hand-computed constants.
module tb_second_game_player_ctrl;

    logic        clk = 1'b0;
    logic        rst, frame_tick, start, bl, br, bu, bd, disp, obs;
    logic [10:0] h;
    logic [9:0]  v;
    logic [8:0]  sq_x;
    logic [9:0]  sq_y;
    logic [1:0]  gs;
    logic        go;
    logic [15:0] score;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    second_game_player_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_start(start),
        .i_btn_left(bl), .i_btn_right(br), .i_btn_up(bu), .i_btn_down(bd),
        .i_disp_enbl(disp), .i_h_coord(h), .i_v_coord(v), .i_is_obstacle(obs),
        .o_screen_square_x(sq_x), .o_screen_square_y(sq_y), .o_game_state(gs),
        .o_game_over(go), .o_score(score)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(2); rst = 1'b0;
        n_chk++; if (gs !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", gs); end
        n_chk++; if (sq_x !== 9'd200) begin n_fail++; $display("FAIL reset_x: got %0d expected 200", sq_x); end
        n_chk++; if (sq_y !== 10'd500) begin n_fail++; $display("FAIL reset_y: got %0d expected 500", sq_y); end
        n_chk++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_chk++; if (go !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %0d expected 0", go); end
    endtask

    task automatic test_start_hold();
        start = 1'b1; cyc(1);
        n_chk++; if (gs !== 2'd1) begin n_fail++; $display("FAIL start_play: got %0d expected 1", gs); end
        cyc(9);
        n_chk++; if (gs !== 2'd1) begin n_fail++; $display("FAIL start_hold: got %0d expected 1", gs); end
        n_chk++; if (score !== 16'd0) begin n_fail++; $display("FAIL start_score: got %0d expected 0", score); end
        n_chk++; if (sq_x !== 9'd200 || sq_y !== 10'd500) begin n_fail++; $display("FAIL start_pos: got %0d,%0d expected 200,500", sq_x, sq_y); end
        start = 1'b0; cyc(1);
    endtask

    task automatic test_collision_miss();
        h = 11'd221; v = 10'd490; disp = 1'b1; obs = 1'b1; cyc(1);
        obs = 1'b0; disp = 1'b0; tick();
        n_chk++; if (gs !== 2'd1 || score !== 16'd1) begin n_fail++; $display("FAIL miss_h221: got state %0d score %0d expected 1,1", gs, score); end
        h = 11'd215; disp = 1'b0; obs = 1'b1; cyc(1);
        obs = 1'b0; tick();
        n_chk++; if (gs !== 2'd1 || score !== 16'd2) begin n_fail++; $display("FAIL miss_disp0: got state %0d score %0d expected 1,2", gs, score); end
    endtask

    task automatic test_collision_hit();
        h = 11'd215; v = 10'd490; disp = 1'b1; obs = 1'b1; cyc(1);
        obs = 1'b0; disp = 1'b0; cyc(3);
        n_chk++; if (gs !== 2'd1) begin n_fail++; $display("FAIL hit_pending_wait: got %0d expected 1", gs); end
        tick();
        n_chk++; if (gs !== 2'd2 || go !== 1'b1) begin n_fail++; $display("FAIL hit_dead: got state %0d over %0d expected 2,1", gs, go); end
        n_chk++; if (sq_x !== 9'd200 || sq_y !== 10'd500 || score !== 16'd2) begin n_fail++; $display("FAIL hit_frozen: got %0d,%0d score %0d expected 200,500,2", sq_x, sq_y, score); end
        br = 1'b1; tick(); br = 1'b0;
        n_chk++; if (sq_x !== 9'd200 || gs !== 2'd2) begin n_fail++; $display("FAIL dead_no_move: got x %0d state %0d expected 200,2", sq_x, gs); end
    endtask

    task automatic test_dead_restart();
        start = 1'b1; cyc(1); start = 1'b0;
        n_chk++; if (gs !== 2'd0 || go !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got state %0d over %0d expected 0,0", gs, go); end
        n_chk++; if (sq_x !== 9'd200 || sq_y !== 10'd500 || score !== 16'd2) begin n_fail++; $display("FAIL restart_pos: got %0d,%0d score %0d expected 200,500,2", sq_x, sq_y, score); end
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        n_chk++; if (gs !== 2'd1 || score !== 16'd0) begin n_fail++; $display("FAIL replay: got state %0d score %0d expected 1,0", gs, score); end
        cyc(1);
    endtask

    task automatic test_move_right();
        br = 1'b1;
        repeat (44) tick();
        n_chk++; if (sq_x !== 9'd376) begin n_fail++; $display("FAIL right_44: got %0d expected 376", sq_x); end
        tick();
`ifdef SECOND_GAME_WRAP_X_EN
        n_chk++; if (sq_x !== 9'd20) begin n_fail++; $display("FAIL wrap_right: got %0d expected 20", sq_x); end
        br = 1'b0; bl = 1'b1; tick(); bl = 1'b0;
        n_chk++; if (sq_x !== 9'd379) begin n_fail++; $display("FAIL wrap_left: got %0d expected 379", sq_x); end
`else
        n_chk++; if (sq_x !== 9'd379) begin n_fail++; $display("FAIL right_45: got %0d expected 379", sq_x); end
        repeat (5) tick();
        n_chk++; if (sq_x !== 9'd379 || score !== 16'd50) begin n_fail++; $display("FAIL right_50: got x %0d score %0d expected 379,50", sq_x, score); end
`endif
        bl = 1'b1; br = 1'b1; tick();
        n_chk++; if (sq_x !== 9'd379) begin n_fail++; $display("FAIL both_lr: got %0d expected 379", sq_x); end
        br = 1'b0; tick(); bl = 1'b0;
        n_chk++; if (sq_x !== 9'd375 || sq_y !== 10'd500) begin n_fail++; $display("FAIL left_step: got %0d,%0d expected 375,500", sq_x, sq_y); end
    endtask

    task automatic test_move_up();
        bu = 1'b1;
        repeat (119) tick();
        n_chk++; if (sq_y !== 10'd24) begin n_fail++; $display("FAIL up_119: got %0d expected 24", sq_y); end
        tick();
        n_chk++; if (sq_y !== 10'd20) begin n_fail++; $display("FAIL up_120: got %0d expected 20", sq_y); end
        repeat (80) tick(); bu = 1'b0;
        n_chk++; if (sq_y !== 10'd20 || sq_x !== 9'd375) begin n_fail++; $display("FAIL up_200: got %0d,%0d expected 375,20", sq_x, sq_y); end
    endtask

    task automatic test_same_cycle();
        h = 11'd370; v = 10'd10; disp = 1'b1; obs = 1'b1; tick();
        obs = 1'b0; disp = 1'b0;
        n_chk++; if (gs !== 2'd2 || sq_x !== 9'd375 || sq_y !== 10'd20) begin n_fail++; $display("FAIL hit_on_tick: got state %0d pos %0d,%0d expected 2,375,20", gs, sq_x, sq_y); end
        br = 1'b1; start = 1'b1; tick(); start = 1'b0;
        n_chk++; if (gs !== 2'd0 || sq_x !== 9'd200 || sq_y !== 10'd500) begin n_fail++; $display("FAIL tick_restart: got state %0d pos %0d,%0d expected 0,200,500", gs, sq_x, sq_y); end
        cyc(1);
        start = 1'b1; tick(); start = 1'b0; br = 1'b0;
        n_chk++; if (gs !== 2'd1 || score !== 16'd0 || sq_x !== 9'd200) begin n_fail++; $display("FAIL tick_start: got state %0d score %0d x %0d expected 1,0,200", gs, score, sq_x); end
    endtask

    task automatic test_reset_mid_play();
        br = 1'b1; repeat (37) tick(); br = 1'b0;
        n_chk++; if (score !== 16'd37 || sq_x !== 9'd348) begin n_fail++; $display("FAIL play_37: got score %0d x %0d expected 37,348", score, sq_x); end
        h = 11'd348; v = 10'd500; disp = 1'b1; obs = 1'b1; cyc(1);
        obs = 1'b0; disp = 1'b0;
        rst = 1'b1; cyc(1); rst = 1'b0;
        n_chk++; if (gs !== 2'd0 || score !== 16'd0 || go !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got state %0d score %0d over %0d expected 0,0,0", gs, score, go); end
        n_chk++; if (sq_x !== 9'd200 || sq_y !== 10'd500) begin n_fail++; $display("FAIL mid_reset_pos: got %0d,%0d expected 200,500", sq_x, sq_y); end
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        tick();
        n_chk++; if (gs !== 2'd1 || score !== 16'd1) begin n_fail++; $display("FAIL hit_discarded: got state %0d score %0d expected 1,1", gs, score); end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0;
        disp = 1'b0; obs = 1'b0; h = '0; v = '0;
        cyc(1);
        test_reset();
        test_start_hold();
        test_collision_miss();
        test_collision_hit();
        test_dead_restart();
        test_move_right();
        test_move_up();
        test_same_cycle();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/second_game_player_ctrl.md
Name: second_game_player_ctrl

Overview:
Upstream stage of the second-game graphics block. Owns the player square's state:
- moves the square once per frame from button inputs, clamped to the playfield;
- detects collision by sampling the obstacle flag at pixels inside the square during the scan;
- runs an IDLE/PLAY/DEAD game state machine with a survived-frames score.

Outputs o_screen_square_x/y feed the graphics block's i_screen_square_x/y directly.

Parameters:
- SECOND_GAME_SCREEN_WIDTH, 400, playfield width in pixels; XW = $clog2(WIDTH) = 9
- SECOND_GAME_SCREEN_HEIGHT, 600, playfield height in pixels; YW = $clog2(HEIGHT) = 10
- SECOND_GAME_PLAYER_SIZE, 20, half-extent of the square; box is [c-SIZE, c+SIZE] inclusive
- SECOND_GAME_INIT_X, 200, square centre x at reset and on restart
- SECOND_GAME_INIT_Y, 500, square centre y at reset and on restart
- SECOND_GAME_STEP, 4, pixels moved per frame per axis

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_frame_tick  in  1  one-cycle pulse at start of vertical blanking
- i_start  in  1  start/restart button, level; edge-detected internally
- i_btn_left, i_btn_right, i_btn_up, i_btn_down  in  1 each  movement buttons, level, pre-debounced
- i_disp_enbl  in  1  display enable from VGA timing
- i_h_coord  in  11  current pixel x
- i_v_coord  in  10  current pixel y
- i_is_obstacle  in  1  obstacle flag for the current pixel, same cycle as coords
- o_screen_square_x  out  XW  square centre x
- o_screen_square_y  out  YW  square centre y
- o_game_state  out  2  0 = IDLE, 1 = PLAY, 2 = DEAD
- o_game_over  out  1  high in DEAD
- o_score  out  16  frames survived in PLAY, saturating at 16'hFFFF

Behaviour:
Reset (i_rst high at a clock edge):
- state = IDLE; x = INIT_X; y = INIT_Y; score = 0; hit_pending = 0; start_prev = 0.

Start edge:
- start_edge = i_start & ~start_prev; start_prev is registered every cycle.

State transitions (all registered):
- IDLE -> PLAY on start_edge; score cleared, hit_pending cleared.
- PLAY -> DEAD on i_frame_tick when hit_pending = 1.
- DEAD -> IDLE on start_edge; x/y return to INIT; score is held until the next IDLE -> PLAY.
- Encoding 3 is unreachable; if entered, it recovers to IDLE next cycle.

Collision detection:
- hit_pending is set in PLAY when all of the following hold in one cycle:
  - i_disp_enbl = 1;
  - i_is_obstacle = 1;
  - x-SIZE <= i_h_coord <= x+SIZE;
  - y-SIZE <= i_v_coord <= y+SIZE.
- Compares are unsigned at 12 bits. Clamping guarantees x >= SIZE and y >= SIZE, so there is no underflow.
- hit_pending is cleared on every i_frame_tick, after it has been evaluated.
- The set and the clear in the same cycle are evaluated together: the tick sees the old value OR the current-cycle hit.

Movement (only on i_frame_tick while in PLAY and not transitioning to DEAD):
- dx = +STEP if right only, -STEP if left only, 0 if both or neither; dy likewise from down/up.
- Clamp x to [SIZE, WIDTH-1-SIZE] = [20, 379] and y to [SIZE, HEIGHT-1-SIZE] = [20, 579].
- Compute in 12-bit signed so that x-STEP below SIZE clamps instead of wrapping.

Score:
- Increments on each i_frame_tick in PLAY that does not transition to DEAD; saturates.

Outputs:
- All outputs are registered. Position/score updates are visible the cycle after i_frame_tick, i.e. within vertical blanking.

Edge cases:
- start_edge in the same cycle as i_frame_tick: the state transition takes priority; no movement and no score change.
- i_rst mid-frame: the whole game state returns to reset values; hit_pending is discarded.

Optional Feature:
- SECOND_GAME_WRAP_X_EN defined:
  - a step past the right bound wraps x to SIZE;
  - a step past the left bound wraps x to WIDTH-1-SIZE;
  - y still clamps.
- Not defined: x clamps as specified above.

Test Plan:
- Reset, then i_start pulse -> state IDLE->PLAY one cycle after the edge; x=200, y=500, score=0. Holding i_start for 10 cycles gives exactly one transition.
- PLAY, i_btn_right held for 50 frame ticks -> x = 379 after 45 ticks, remains 379; left+right together -> x unchanged.
- PLAY, i_btn_up held for 200 ticks -> y saturates at 20.
- PLAY, i_is_obstacle=1 at (h=215, v=490, disp=1), square at (200, 500) -> next tick state=DEAD, o_game_over=1, x/y frozen. Same stimulus at h=221 or with disp=0 -> stays PLAY.
- DEAD, i_start edge -> IDLE, x/y=(200, 500), score held. Next edge -> PLAY, score=0. i_rst mid-PLAY with score=37 -> score=0, IDLE.
- With SECOND_GAME_WRAP_X_EN: x=379, right held one tick -> x=20; x=20, left one tick -> x=379.
